req_encoder8: RTL and testbench
===============================

REQ_ENCODER8 -- requirements
Module: req_encoder8

Interface
REQ-001 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-002 RST_N  input  1  reset; synchronous and active-low.
REQ-003 EN  input  1  capture enable; when 1, REQ bits are latched into PENDING.
REQ-004 REQ  input  8  request lines; multi-hot allowed; bit i requests code i.
REQ-005 MASK  input  8  per-bit mask; 1 excludes that bit from selection but not from capture.
REQ-006 ACK  input  1  consumer acknowledge of the presented code.
REQ-007 CODE  output  3  binary index of the presented request; inverse of the 3-to-8 one-hot select.
REQ-008 VALID  output  1  CODE holds a presented, unacknowledged request.
REQ-009 PENDING  output  8  registered set of captured, unserviced requests.
REQ-010 OVERRUN  output  1  sticky flag: a request arrived on a bit that was already pending.

Function
REQ-011 The block SHALL set PENDING[i] on any edge where EN=1 and REQ[i]=1.
REQ-012 The block SHALL ignore REQ entirely while EN=0; existing PENDING bits and any presentation in progress are unaffected.
REQ-013 The block SHALL use two states: IDLE (VALID=0) and PRESENT (VALID=1).
REQ-014 In IDLE, if (PENDING & ~MASK) is nonzero and EN=1, the block SHALL register CODE as the lowest set index of (PENDING & ~MASK) and move to PRESENT, with VALID=1 from the next cycle.
REQ-015 In IDLE with (PENDING & ~MASK) zero or EN=0, the block SHALL remain in IDLE with CODE holding its last value.
REQ-016 Priority SHALL be fixed: bit 0 highest, bit 7 lowest.
REQ-017 Latency: REQ[i]=1 sampled at edge k into an empty, idle block SHALL give VALID=1 and CODE=i after edge k+1, i.e. two cycles.
REQ-018 In PRESENT, CODE and VALID SHALL stay stable until ACK, regardless of new higher-priority REQ, MASK changes or EN.
REQ-019 On an edge in PRESENT with ACK=1, the block SHALL clear PENDING[CODE], drive VALID=0 and return to IDLE.
REQ-020 Back-to-back presentations are separated by at least one VALID=0 cycle, giving a maximum throughput of one code per two cycles.
REQ-021 ACK while in IDLE SHALL be ignored, with no state or PENDING change.
REQ-022 If REQ[CODE]=1 with EN=1 on the same edge as an accepted ACK, set SHALL win: PENDING[CODE] stays 1, OVERRUN is not set, and the bit is eligible again.
REQ-023 OVERRUN SHALL be set on any edge where EN=1, REQ[i]=1 and PENDING[i]=1, unless that bit is cleared by ACK on that edge; it SHALL clear only on reset.
REQ-024 A masked pending bit SHALL stay pending indefinitely and become eligible in the first IDLE cycle after its mask bit clears.
REQ-025 All outputs SHALL be driven directly from registers.

Reset
REQ-026 On an edge with RST_N=0, the block SHALL force state=IDLE, VALID=0, CODE=3'b000, PENDING=8'h00 and OVERRUN=0, overriding REQ, EN and ACK.
REQ-027 Reset asserted mid-presentation SHALL drop VALID on the following edge and discard all pending requests without reporting them.
REQ-028 The first edge with RST_N=1 SHALL behave as a normal capture edge.

Verification
REQ-029 Single request: EN=1, MASK=00, REQ=8'h20 for one cycle -> PENDING=8'h20 after 1 edge; VALID=1, CODE=5 after 2 edges; ACK -> VALID=0, PENDING=00.
REQ-030 Priority plus hold: REQ=8'h90 -> CODE=4; while VALID, REQ=8'h01 -> CODE stays 4 until ACK; after ACK, one idle cycle, then CODE=0, then after the next ACK CODE=7.
REQ-031 Mask: PENDING=8'h03, MASK=8'h01 -> CODE=1; after ACK, PENDING=01 and VALID stays 0; clear MASK -> CODE=0 two edges later.
REQ-032 Collision and overrun: while presenting CODE=2, REQ=8'h04 without ACK -> OVERRUN=1; REQ=8'h04 on the same edge as ACK -> OVERRUN unchanged, PENDING[2]=1, CODE=2 re-presented.
REQ-033 EN gating and stray ACK: EN=0 with REQ=8'hFF -> PENDING unchanged; ACK=1 in IDLE -> no change.
REQ-034 Reset mid-operation: PENDING=8'hF0, VALID=1, RST_N=0 for one edge -> VALID=0, CODE=0, PENDING=00, OVERRUN=0.

Source files
------------

// File: rtl/req_encoder8.sv
// req_encoder8: captures multi-hot requests, presents lowest unmasked
// pending index as a registered code held until acknowledged.
module req_encoder8 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] REQ,
  input  logic [7:0] MASK,
  input  logic       ACK,
  output logic [2:0] CODE,
  output logic       VALID,
  output logic [7:0] PENDING,
  output logic       OVERRUN
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pend_q, pend_d;
  logic       ovr_q, ovr_d;

  logic [7:0] elig;
  logic       any_elig;
  logic [2:0] low_idx;
  logic       take;
  logic       clr;
  logic [7:0] clr_vec;
  logic [7:0] set_vec;

  // lowest set bit wins: bit 0 has the highest priority
  function automatic logic [2:0] lowest(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign elig     = pend_q & ~MASK;
  assign any_elig = |elig;
  assign low_idx  = lowest(elig);
  assign take     = (state_q == IDLE) && EN && any_elig;
  assign clr      = (state_q == PRESENT) && ACK;
  assign clr_vec  = clr ? (8'h01 << code_q) : 8'h00;
  assign set_vec  = EN ? REQ : 8'h00;

  // state register
  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state: present on an eligible request, drop on acknowledge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take) state_d = PRESENT;
      PRESENT: if (ACK)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values; a new set on the acked bit overrides the clear
  always_comb begin
    code_d = code_q;
    if (take) code_d = low_idx;
    pend_d = (pend_q & ~clr_vec) | set_vec;
    ovr_d  = ovr_q | (|(set_vec & pend_q & ~clr_vec));
  end

  // datapath registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      code_q <= 3'd0;
      pend_q <= 8'h00;
      ovr_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  assign CODE    = code_q;
  assign VALID   = (state_q == PRESENT);
  assign PENDING = pend_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_req_encoder8.sv
// tb_req_encoder8: directed checks of capture, priority, hold,
// masking, overrun, enable gating and reset behaviour.
module tb_req_encoder8;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN;
  logic [7:0] REQ;
  logic [7:0] MASK;
  logic       ACK;
  logic [2:0] CODE;
  logic       VALID;
  logic [7:0] PENDING;
  logic       OVERRUN;

  int tests = 0;
  int fails = 0;

  req_encoder8 dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .EN(EN),
    .REQ(REQ),
    .MASK(MASK),
    .ACK(ACK),
    .CODE(CODE),
    .VALID(VALID),
    .PENDING(PENDING),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic v, input logic [2:0] c,
                    input logic [7:0] p);
    chk({tag, "_valid"}, {7'd0, VALID}, {7'd0, v});
    if (v) chk({tag, "_code"}, {5'd0, CODE}, {5'd0, c});
    chk({tag, "_pend"}, PENDING, p);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; REQ = 8'h00; MASK = 8'h00; ACK = 1'b0;
    step(); step();
    chk("rst_valid", {7'd0, VALID}, 8'h00);
    chk("rst_code", {5'd0, CODE}, 8'h00);
    chk("rst_pend", PENDING, 8'h00);
    chk("rst_ovr", {7'd0, OVERRUN}, 8'h00);
    RST_N = 1'b1;

    EN = 1'b1; REQ = 8'h20; step();
    st("single_cap", 1'b0, 3'd0, 8'h20);
    REQ = 8'h00; step();
    st("single_pres", 1'b1, 3'd5, 8'h20);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("single_ack", 1'b0, 3'd0, 8'h00);

    REQ = 8'h90; step();
    REQ = 8'h00; step();
    st("prio_pres", 1'b1, 3'd4, 8'h90);
    REQ = 8'h01; step();
    st("prio_hold1", 1'b1, 3'd4, 8'h91);
    REQ = 8'h00; step();
    st("prio_hold2", 1'b1, 3'd4, 8'h91);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("prio_ack4", 1'b0, 3'd0, 8'h81);
    step();
    st("prio_code0", 1'b1, 3'd0, 8'h81);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("prio_ack0", 1'b0, 3'd0, 8'h80);
    step();
    st("prio_code7", 1'b1, 3'd7, 8'h80);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("prio_ack7", 1'b0, 3'd0, 8'h00);
    chk("prio_ovr", {7'd0, OVERRUN}, 8'h00);

    MASK = 8'h01; REQ = 8'h03; step();
    REQ = 8'h00; step();
    st("mask_pres", 1'b1, 3'd1, 8'h03);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("mask_ack", 1'b0, 3'd0, 8'h01);
    step(); step();
    st("mask_held", 1'b0, 3'd0, 8'h01);
    MASK = 8'h00; step(); step();
    st("mask_rel", 1'b1, 3'd0, 8'h01);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("mask_done", 1'b0, 3'd0, 8'h00);

    REQ = 8'h04; step();
    REQ = 8'h00; step();
    st("ovr_pres", 1'b1, 3'd2, 8'h04);
    chk("ovr_pre", {7'd0, OVERRUN}, 8'h00);
    REQ = 8'h04; step();
    chk("ovr_set", {7'd0, OVERRUN}, 8'h01);
    st("ovr_hold", 1'b1, 3'd2, 8'h04);
    ACK = 1'b1; step(); ACK = 1'b0; REQ = 8'h00;
    st("ovr_setwin", 1'b0, 3'd0, 8'h04);
    chk("ovr_sticky", {7'd0, OVERRUN}, 8'h01);
    step();
    st("ovr_repres", 1'b1, 3'd2, 8'h04);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("ovr_done", 1'b0, 3'd0, 8'h00);

    EN = 1'b0; REQ = 8'hFF; step();
    st("en_gate", 1'b0, 3'd0, 8'h00);
    EN = 1'b1; REQ = 8'h08; step();
    EN = 1'b0; REQ = 8'h00; step();
    st("en_nopres", 1'b0, 3'd0, 8'h08);
    ACK = 1'b1; step(); ACK = 1'b0;
    st("stray_ack", 1'b0, 3'd0, 8'h08);
    EN = 1'b1; step();
    st("en_pres", 1'b1, 3'd3, 8'h08);
    EN = 1'b0; ACK = 1'b1; step(); ACK = 1'b0; EN = 1'b1;
    st("en_ack", 1'b0, 3'd0, 8'h00);

    REQ = 8'hF0; step();
    REQ = 8'h00; step();
    st("rstm_pres", 1'b1, 3'd4, 8'hF0);
    RST_N = 1'b0; REQ = 8'h0F; ACK = 1'b1; step();
    RST_N = 1'b1; ACK = 1'b0;
    chk("rstm_valid", {7'd0, VALID}, 8'h00);
    chk("rstm_code", {5'd0, CODE}, 8'h00);
    chk("rstm_pend", PENDING, 8'h00);
    chk("rstm_ovr", {7'd0, OVERRUN}, 8'h00);
    REQ = 8'h02; step();
    st("rstm_cap", 1'b0, 3'd0, 8'h02);
    REQ = 8'h00; step();
    st("sw_pres", 1'b1, 3'd1, 8'h02);
    REQ = 8'h02; ACK = 1'b1; step();
    REQ = 8'h00; ACK = 1'b0;
    st("sw_keep", 1'b0, 3'd0, 8'h02);
    chk("sw_noovr", {7'd0, OVERRUN}, 8'h00);
    step();
    st("sw_repres", 1'b1, 3'd1, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
